cache_controller: RTL and testbench
===================================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 16: number of cache entries and width of the one-hot index.
REQ-002 SHALL have parameter KEY_WIDTH, default 16: key width.
REQ-003 SHALL have parameter VALUE_WIDTH, default 64: value width.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  in  1  request present.
REQ-007 SHALL have port req_ready  out  1  request accepted when req_valid && req_ready.
REQ-008 SHALL have port req_op  in  2  request opcode: NOP=00, GET=01, PUT=10, DEL=11.
REQ-009 SHALL have port req_key  in  KEY_WIDTH  request key; zero is illegal.
REQ-010 SHALL have port req_value  in  VALUE_WIDTH  PUT data.
REQ-011 SHALL have port rsp_valid  out  1  response present.
REQ-012 SHALL have port rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
REQ-013 SHALL have port rsp_status  out  2  response status: OK=00, MISS=01, FULL=10, ERR=11.
REQ-014 SHALL have port rsp_value  out  VALUE_WIDTH  GET data; zero for every other opcode.
REQ-015 SHALL have port count  out  $clog2(NUM_ENTRIES+1)  number of occupied entries.
REQ-016 SHALL have memory-side output ports mem_write (1), mem_select_by_index (1), mem_delete (1), mem_key (KEY_WIDTH), mem_value (VALUE_WIDTH) and mem_index (NUM_ENTRIES), all driving the storage array.
REQ-017 SHALL have memory-side input ports mem_value_out (VALUE_WIDTH), mem_index_out (NUM_ENTRIES) and mem_hit (1), all combinational results of the storage array's key match.

Function
REQ-018 SHALL implement the FSM IDLE -> LOOKUP -> EXEC -> RESP -> IDLE; req_ready=1 only in IDLE.
REQ-019 SHALL in IDLE, on handshake, register op/key/value; if op=NOP or key=0, go directly to RESP with status ERR and issue no memory access; otherwise go to LOOKUP.
REQ-020 SHALL in LOOKUP drive mem_key=latched key with mem_select_by_index=0, mem_write=0, mem_delete=0, and register mem_hit, mem_index_out and mem_value_out.
REQ-021 SHALL in EXEC for GET drive no strobes; status=OK with rsp_value=captured value on hit, status=MISS with rsp_value=0 otherwise.
REQ-022 SHALL in EXEC for PUT on hit pulse mem_write for one cycle with mem_index=hit index (in-place update); count unchanged; status OK.
REQ-023 SHALL in EXEC for PUT on miss with a free slot pulse mem_write with mem_index=lowest free slot (one-hot), set that used_map bit, increment count; status OK.
REQ-024 SHALL in EXEC for PUT on miss with used_map all ones issue no write; status FULL.
REQ-025 SHALL in EXEC for DEL on hit pulse mem_delete for one cycle with mem_index=hit index, clear that used_map bit, decrement count; status OK.
REQ-026 SHALL in EXEC for DEL on miss issue no strobe; status MISS.
REQ-027 SHALL keep mem_key and mem_value at the latched request values during LOOKUP and EXEC; mem_index SHALL be zero outside EXEC.
REQ-028 SHALL hold rsp_valid=1 in RESP with rsp_status and rsp_value stable until rsp_ready; on the handshake cycle return to IDLE.
REQ-029 SHALL provide accept-to-rsp_valid latency of 3 cycles for memory ops and 1 cycle for ERR.
REQ-030 SHALL have mem_write and mem_delete mutually exclusive and each asserted for at most one cycle per request.
REQ-031 SHALL have count equal popcount(used_map) and never exceed NUM_ENTRIES.

Reset
REQ-032 SHALL, on rst_n low at any time including mid-request, asynchronously enter IDLE, clear used_map, set count=0, and drive all outputs to 0 except req_ready, which is 1 after reset release.
REQ-033 SHALL lose any in-flight request on reset, producing no response; the storage array shares rst_n and is cleared with it.

Structure
REQ-034 SHALL place op_e, status_e and the FSM state enum in a shared package cache_pkg.
REQ-035 SHALL use one sub-module free_slot_finder: a combinational lowest-zero priority encoder over used_map, outputting a one-hot slot and a found flag.

Verification
REQ-036 SHALL cover, with NUM_ENTRIES=4: PUT key 0x0011 value 0xAA -> mem_write with mem_index=0001; rsp OK 3 cycles after accept; count=1.
REQ-037 SHALL cover GET 0x0011 -> OK with rsp_value 0xAA, followed by GET 0x0022 -> MISS with rsp_value 0.
REQ-038 SHALL cover 4 PUTs with distinct keys, then PUT 0x0055 -> FULL with no mem_write; PUT of an existing key with new value 0xBB -> in-place write, count stays 4.
REQ-039 SHALL cover DEL of the key in slot 0010 -> mem_delete with mem_index=0010, count=3; next PUT of a new key -> writes index 0010.
REQ-040 SHALL cover PUT with key 0 -> ERR after 1 cycle with no strobes, and rsp_ready held low 5 cycles -> response stable and req_ready=0 throughout.
REQ-041 SHALL cover rst_n asserted during EXEC -> no response, count=0, req_ready=1 after reset release.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types for the key/value cache controller: opcodes, response status, FSM states.
package cache_pkg;
  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_GET = 2'b01, OP_PUT = 2'b10, OP_DEL = 2'b11} op_e;
  typedef enum logic [1:0] {ST_OK = 2'b00, ST_MISS = 2'b01, ST_FULL = 2'b10, ST_ERR = 2'b11} status_e;
  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_EXEC, S_RESP} state_e;
endpackage

// File: rtl/cache_controller_free_slot_finder.sv
// Lowest-zero priority encoder over the occupancy map; one-hot slot plus found flag.
module free_slot_finder #(
  parameter int NUM_ENTRIES = 16
) (
  input  logic [NUM_ENTRIES-1:0] used_map,
  output logic [NUM_ENTRIES-1:0] slot,
  output logic                   found
);
  always_comb begin
    slot  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!used_map[i] && !found) begin
        slot[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cache_controller.sv
// Request/response front end for a keyed storage array: lookup, then update/delete by index.
module cache_controller
  import cache_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int KEY_WIDTH   = 16,
  parameter int VALUE_WIDTH = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [1:0]                     req_op,
  input  logic [KEY_WIDTH-1:0]           req_key,
  input  logic [VALUE_WIDTH-1:0]         req_value,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [1:0]                     rsp_status,
  output logic [VALUE_WIDTH-1:0]         rsp_value,
  output logic [$clog2(NUM_ENTRIES+1)-1:0] count,
  output logic                           mem_write,
  output logic                           mem_select_by_index,
  output logic                           mem_delete,
  output logic [KEY_WIDTH-1:0]           mem_key,
  output logic [VALUE_WIDTH-1:0]         mem_value,
  output logic [NUM_ENTRIES-1:0]         mem_index,
  input  logic [VALUE_WIDTH-1:0]         mem_value_out,
  input  logic [NUM_ENTRIES-1:0]         mem_index_out,
  input  logic                           mem_hit
);
  localparam int CW = $clog2(NUM_ENTRIES+1);

  state_e                 state;
  op_e                    op_q;
  logic                   hit_q, found_q;
  logic [VALUE_WIDTH-1:0] val_q;
  logic [NUM_ENTRIES-1:0] used_map, free_slot;
  logic                   free_found;

  free_slot_finder #(.NUM_ENTRIES(NUM_ENTRIES)) u_free (
    .used_map (used_map),
    .slot     (free_slot),
    .found    (free_found)
  );

  // Held low while reset is asserted, high in IDLE afterwards.
  assign req_ready = rst_n & (state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= S_IDLE;
      op_q                <= OP_NOP;
      hit_q               <= 1'b0;
      found_q             <= 1'b0;
      val_q               <= '0;
      used_map            <= '0;
      count               <= '0;
      rsp_valid           <= 1'b0;
      rsp_status          <= '0;
      rsp_value           <= '0;
      mem_write           <= 1'b0;
      mem_select_by_index <= 1'b0;
      mem_delete          <= 1'b0;
      mem_key             <= '0;
      mem_value           <= '0;
      mem_index           <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          op_q <= op_e'(req_op);
          if (req_op == OP_NOP || req_key == '0) begin
            rsp_valid  <= 1'b1;
            rsp_status <= ST_ERR;
            rsp_value  <= '0;
            state      <= S_RESP;
          end else begin
            mem_key   <= req_key;
            mem_value <= req_value;
            state     <= S_LOOKUP;
          end
        end
        // Strobes are decided here from the live match so they are registered into EXEC.
        S_LOOKUP: begin
          hit_q   <= mem_hit;
          val_q   <= mem_value_out;
          found_q <= free_found;
          case (op_q)
            OP_PUT: begin
              if (mem_hit || free_found) begin
                mem_write           <= 1'b1;
                mem_select_by_index <= 1'b1;
                mem_index           <= mem_hit ? mem_index_out : free_slot;
              end
            end
            OP_DEL: begin
              if (mem_hit) begin
                mem_delete          <= 1'b1;
                mem_select_by_index <= 1'b1;
                mem_index           <= mem_index_out;
              end
            end
            default: ;
          endcase
          state <= S_EXEC;
        end
        S_EXEC: begin
          mem_write           <= 1'b0;
          mem_delete          <= 1'b0;
          mem_select_by_index <= 1'b0;
          mem_index           <= '0;
          mem_key             <= '0;
          mem_value           <= '0;
          rsp_valid           <= 1'b1;
          rsp_value           <= '0;
          rsp_status          <= ST_OK;
          case (op_q)
            OP_GET: begin
              rsp_status <= hit_q ? ST_OK : ST_MISS;
              rsp_value  <= hit_q ? val_q : '0;
            end
            OP_PUT: begin
              if (!hit_q && found_q) begin
                used_map <= used_map | mem_index;
                count    <= count + CW'(1);
              end else if (!hit_q) begin
                rsp_status <= ST_FULL;
              end
            end
            OP_DEL: begin
              if (hit_q) begin
                used_map <= used_map & ~mem_index;
                count    <= count - CW'(1);
              end else begin
                rsp_status <= ST_MISS;
              end
            end
            default: rsp_status <= ST_ERR;
          endcase
          state <= S_RESP;
        end
        S_RESP: if (rsp_ready) begin
          rsp_valid  <= 1'b0;
          rsp_status <= '0;
          rsp_value  <= '0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_controller.sv
// Randomized bench for cache_controller with a behavioural storage array and key/value reference model.
module tb_cache_controller;
  localparam int N  = 4;
  localparam int KW = 16;
  localparam int VW = 64;
  localparam int CW = $clog2(N+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_ready;
  logic [1:0]    req_op = '0;
  logic [KW-1:0] req_key = '0;
  logic [VW-1:0] req_value = '0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [1:0]    rsp_status;
  logic [VW-1:0] rsp_value;
  logic [CW-1:0] count;
  logic          mem_write, mem_select_by_index, mem_delete;
  logic [KW-1:0] mem_key;
  logic [VW-1:0] mem_value;
  logic [N-1:0]  mem_index;
  logic [VW-1:0] mem_value_out;
  logic [N-1:0]  mem_index_out;
  logic          mem_hit;

  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  cache_controller #(.NUM_ENTRIES(N), .KEY_WIDTH(KW), .VALUE_WIDTH(VW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_key(req_key), .req_value(req_value), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_value(rsp_value), .count(count), .mem_write(mem_write),
    .mem_select_by_index(mem_select_by_index), .mem_delete(mem_delete), .mem_key(mem_key),
    .mem_value(mem_value), .mem_index(mem_index), .mem_value_out(mem_value_out),
    .mem_index_out(mem_index_out), .mem_hit(mem_hit)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Storage array: combinational key match, indexed write/delete, cleared with rst_n.
  logic          st_vld [N];
  logic [KW-1:0] st_key [N];
  logic [VW-1:0] st_val [N];

  always_comb begin
    mem_hit = 1'b0;
    mem_index_out = '0;
    mem_value_out = '0;
    for (int i = 0; i < N; i++)
      if (st_vld[i] && st_key[i] == mem_key && !mem_hit) begin
        mem_hit = 1'b1;
        mem_index_out[i] = 1'b1;
        mem_value_out = st_val[i];
      end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        st_vld[i] <= 1'b0; st_key[i] <= '0; st_val[i] <= '0;
      end
    end else begin
      if (mem_write || mem_delete) chk("strobe_excl", 64'(mem_write & mem_delete), 64'd0);
      for (int i = 0; i < N; i++) begin
        if (mem_write && mem_index[i]) begin
          st_vld[i] <= 1'b1; st_key[i] <= mem_key; st_val[i] <= mem_value;
        end
        if (mem_delete && mem_index[i]) st_vld[i] <= 1'b0;
      end
    end
  end

  // Reference model: slot-ordered key/value table with lowest-free allocation.
  logic          m_vld [N];
  logic [KW-1:0] m_key [N];
  logic [VW-1:0] m_val [N];

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_vld[i]);
    return c;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < N; i++) begin m_vld[i] = 1'b0; m_key[i] = '0; m_val[i] = '0; end
  endtask

  // Issue one request starting at a negedge; returns at a negedge with the DUT back in IDLE.
  task automatic do_req(input logic [1:0] op, input logic [KW-1:0] key, input logic [VW-1:0] val,
                        input int hold);
    int hit = -1, free = -1, lat, e_lat, wr_n = 0, del_n = 0;
    logic [1:0]   e_st;
    logic [VW-1:0] e_val = '0, s_val;
    logic [N-1:0] e_idx = '0, wr_idx = '0, del_idx = '0;
    logic         e_wr = 1'b0, e_del = 1'b0;
    logic [1:0]   s_st;
    for (int i = N-1; i >= 0; i--) begin
      if (m_vld[i] && m_key[i] == key) hit = i;
      if (!m_vld[i]) free = i;
    end
    e_lat = 3;
    if (op == 2'b00 || key == '0) begin
      e_st = 2'b11; e_lat = 1;
    end else if (op == 2'b01) begin
      e_st = (hit >= 0) ? 2'b00 : 2'b01;
      if (hit >= 0) e_val = m_val[hit];
    end else if (op == 2'b10) begin
      if (hit >= 0) begin
        e_st = 2'b00; e_wr = 1'b1; e_idx = N'(1) << hit; m_val[hit] = val;
      end else if (free >= 0) begin
        e_st = 2'b00; e_wr = 1'b1; e_idx = N'(1) << free;
        m_vld[free] = 1'b1; m_key[free] = key; m_val[free] = val;
      end else e_st = 2'b10;
    end else begin
      if (hit >= 0) begin
        e_st = 2'b00; e_del = 1'b1; e_idx = N'(1) << hit; m_vld[hit] = 1'b0;
      end else e_st = 2'b01;
    end

    chk("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_op = op; req_key = key; req_value = val;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    req_valid = 1'b0;
    while (!rsp_valid && lat < 10) begin
      if (mem_write)  begin wr_n++;  wr_idx  = mem_index; end
      if (mem_delete) begin del_n++; del_idx = mem_index; end
      @(posedge clk); lat++; @(negedge clk);
    end
    chk("latency", 64'(lat), 64'(e_lat));
    if (!rsp_valid) begin
      chk("rsp_timeout", 64'd0, 64'd1);
      return;
    end
    chk("status", 64'(rsp_status), 64'(e_st));
    chk("rsp_value", rsp_value, e_val);
    chk("write_cnt", 64'(wr_n), 64'(e_wr));
    chk("delete_cnt", 64'(del_n), 64'(e_del));
    if (e_wr)  chk("write_idx", 64'(wr_idx), 64'(e_idx));
    if (e_del) chk("delete_idx", 64'(del_idx), 64'(e_idx));
    s_st = rsp_status; s_val = rsp_value;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_status", 64'(rsp_status), 64'(s_st));
      chk("hold_value", rsp_value, s_val);
      chk("hold_ready", 64'(req_ready), 64'd0);
      chk("hold_nostrobe", 64'({mem_write, mem_delete}), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done", 64'(rsp_valid), 64'd0);
    chk("count", 64'(count), 64'(m_count()));
  endtask

  initial begin
    m_clear();
    #12;
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_mem", 64'({mem_write, mem_delete, mem_select_by_index, mem_index}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", 64'(req_ready), 64'd1);

    do_req(2'b10, 16'h0011, 64'hAA, 0);
    do_req(2'b01, 16'h0011, 64'h0, 0);
    do_req(2'b01, 16'h0022, 64'h0, 1);
    do_req(2'b10, 16'h0022, 64'h22, 0);
    do_req(2'b10, 16'h0033, 64'h33, 0);
    do_req(2'b10, 16'h0044, 64'h44, 0);
    chk("full_count", 64'(count), 64'd4);
    do_req(2'b10, 16'h0055, 64'h55, 0);
    do_req(2'b10, 16'h0022, 64'hBB, 0);
    do_req(2'b01, 16'h0022, 64'h0, 0);
    do_req(2'b11, 16'h0022, 64'h0, 0);
    do_req(2'b10, 16'h0066, 64'h66, 0);
    do_req(2'b11, 16'h0077, 64'h0, 0);
    do_req(2'b10, 16'h0000, 64'h12, 5);
    do_req(2'b00, 16'h0011, 64'h0, 0);

    // Reset while the request sits in EXEC: no response, state cleared.
    req_valid = 1'b1; req_op = 2'b10; req_key = 16'h0099; req_value = 64'h99;
    @(posedge clk); @(negedge clk); req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0; #1;
    m_clear();
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_strobe", 64'({mem_write, mem_delete}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_ready", 64'(req_ready), 64'd1);
      chk("post_rst_valid", 64'(rsp_valid), 64'd0);
    end
    chk("post_rst_count", 64'(count), 64'd0);
    do_req(2'b01, 16'h0011, 64'h0, 0);

    for (int t = 0; t < 150; t++) begin
      logic [1:0]    op;
      logic [KW-1:0] key;
      op  = 2'($urandom_range(0, 3));
      key = ($urandom_range(0, 11) == 0) ? '0 : KW'($urandom_range(1, 6));
      do_req(op, key, {$urandom, $urandom}, int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
